mult16_iter: RTL and testbench
==============================

// Module: mult16_iter
// PURPOSE
//  Iterative 16x16 unsigned shift-and-add multiplier for the execute stage.
//  Feeds one fulladder16 instance with the running partial sum and the
//  multiplicand, and consumes its sum and carry-out once per cycle.
//  Returns a 32-bit product after a fixed 16 iterations.
//  Uses a start/busy/done handshake and a pipeline flush input.
// PARAMETERS
//  WIDTH   16  operand width; only 16 is supported (fulladder16 is fixed-width)
//  CNT_W   5   iteration counter width; must hold the value 16
// PORTS
//  clk      in   1   system clock, rising edge
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   request; accepted only in IDLE or DONE
//  flush    in   1   pipeline flush; aborts any operation
//  a        in   16  multiplicand; sampled on the accepting edge
//  b        in   16  multiplier; sampled on the accepting edge
//  busy     out  1   high while state==RUN
//  done     out  1   high for exactly one cycle (state==DONE) when product is valid
//  product  out  32  {H,L}; valid while done; holds until the next accept or flush
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, M=0, H=0, L=0, C=0, cnt=0,
//    busy=0, done=0, product=0. Reset mid-operation discards all work.
//  - Registers:
//    - M[15:0]: multiplicand.
//    - H[15:0]: high accumulator.
//    - L[15:0]: multiplier shifting into the product low half.
//    - cnt[4:0]: iteration counter.
//  - Adder hookup: fulladder16.A=H, .B=(L[0] ? M : 16'h0), producing S and Cout.
//  - FSM states: IDLE, RUN, DONE (2-bit encoding).
//  - IDLE:
//    - start & !flush -> RUN; M<=a, H<=0, L<=b, cnt<=0.
//    - Otherwise stay in IDLE.
//  - RUN, on each edge:
//    - {H,L} <= {Cout,S,L[15:1]} (33-bit shift right, carry into H[15]).
//    - cnt <= cnt+1.
//    - When cnt==15 on this edge -> DONE.
//    - start is ignored while in RUN.
//  - DONE:
//    - done=1.
//    - start & !flush -> RUN with new operands (back-to-back; no IDLE gap).
//    - Otherwise -> IDLE. H and L hold.
//  - Latency: start accepted at edge 0; iterations on edges 1..16; done is high
//    in the cycle following edge 16. Total 17 cycles from the start edge to done.
//  - flush, any state:
//    - Next state is IDLE; H, L, cnt cleared; done is never asserted for the
//      aborted operation.
//    - flush and start in the same cycle: flush wins and start is dropped.
//  - Arithmetic: unsigned modulo-2^32 is exact (no overflow possible).
//    - b==0 and a==0 still take the full 16 iterations.
//    - The carry from the adder must be kept; dropping it corrupts large products.
//  - Outputs are decoded directly from registers (no combinational path from inputs).
// STRUCTURE
//  - Shared package mult_pkg:
//    - ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//    - MULT_WIDTH=16, MULT_ITERS=16.
//  - Sub-module: one fulladder16 instance, the sole adder; no behavioural '+'
//    on the datapath.
//  - The counter increment (cnt+1) may be behavioural.
// TESTING
//  - 3*5 -> busy for 16 cycles, done pulses in the 17th cycle after start;
//    product=32'h0000000F.
//  - 16'hFFFF*16'hFFFF -> product=32'hFFFE0001 (exercises the Cout path);
//    8000*0002 -> 32'h00010000.
//  - start pulsed while busy with a=7, b=7 -> ignored; the original product is
//    returned; done is asserted once.
//  - flush at cycle 8 of RUN -> next cycle IDLE, busy=0, product=0, no done;
//    a following start 2*9 -> 32'h00000012.
//  - start held in the DONE cycle with a=4, b=4 -> no IDLE gap; first product
//    seen, then 32'h00000010 exactly 17 cycles later.
//  - rst_n low at cycle 5 of RUN -> all outputs 0 immediately (async);
//    after release, 0*1234 -> 32'h0 with full 17-cycle latency.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding,
// operand width and iteration count.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_ITERS = 16;

endpackage

// File: rtl/fulladder16.sv
// 16-bit ripple-carry adder, no carry-in.
// Ports:
//   a, b  : 16-bit addends
//   s     : 16-bit sum
//   cout  : carry out of bit 15
module fulladder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout
);

  logic carry;

  // Carry is walked bit by bit in a variable so no '+' operator is used.
  always_comb begin
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < 16; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mult16_iter.sv
// Iterative 16x16 unsigned shift-and-add multiplier. One add-and-shift per
// cycle through a single fulladder16; 32-bit product after 16 iterations.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request, accepted in IDLE or DONE
//   flush    : aborts any operation, returns to IDLE
//   a, b     : multiplicand / multiplier, sampled on the accepting edge
//   busy     : high while iterating
//   done     : one-cycle pulse, product valid
//   product  : {H,L}; holds until the next accept or flush
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | iterating, one add-and-shift per cycle
// ST_DONE | product valid, done high for this cycle
module mult16_iter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITERS - 1);

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   h;
  logic [WIDTH-1:0]   l;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  assign addend = l[0] ? m : '0;

  fulladder16 u_add (
    .a    (h),
    .b    (addend),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      m     <= '0;
      h     <= '0;
      l     <= '0;
      cnt   <= '0;
    end else if (flush) begin
      // Flush beats a simultaneous start; the aborted result is discarded.
      state <= ST_IDLE;
      h     <= '0;
      l     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            m     <= a;
            h     <= '0;
            l     <= b;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // 33-bit right shift of {cout,sum,l}; consumed multiplier bits
          // fall off the bottom while product bits enter l from the top.
          h   <= {cout, sum[WIDTH-1:1]};
          l   <= {sum[0], l[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign product = {h, l};

endmodule

// File: tb/tb_mult16_iter.sv
module tb_mult16_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int vectors = 0;
  int errors  = 0;

  mult16_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Starts one operation and waits (bounded) for done. lat counts cycles
  // after the accepting edge; done is expected at lat==16.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        output int lat, output int bcnt, output logic [31:0] res);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({busy, done, product} !== 34'h0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b product=%h expected all 0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, product} !== 34'h0) begin
      errors++; $display("FAIL reset_release: got busy=%b done=%b product=%h expected all 0", busy, done, product);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    int lat, bcnt;
    logic [31:0] res, exp;
    ta = '{16'h0003, 16'hFFFF, 16'h8000};
    tb = '{16'h0005, 16'hFFFF, 16'h0002};
    for (int i = 0; i < 3; i++) begin
      exp = ref_mul(ta[i], tb[i]);
      run_op(ta[i], tb[i], lat, bcnt, res);
      vectors++;
      if (res !== exp) begin
        errors++; $display("FAIL directed_product[%0d]: got %h expected %h", i, res, exp);
      end
      vectors++;
      if (lat != 16) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d expected 16", i, lat);
      end
      vectors++;
      if (bcnt != 16) begin
        errors++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 16", i, bcnt);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || product !== exp) begin
        errors++; $display("FAIL directed_hold[%0d]: got done=%b product=%h expected done=0 product=%h", i, done, product, exp);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [15:0] ra, rb;
    logic [31:0] res, exp;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) rb = 16'h0;
      if (i % 9 == 4) ra = 16'h0;
      exp = ref_mul(ra, rb);
      run_op(ra, rb, lat, bcnt, res);
      vectors++;
      if (res !== exp || lat != 16) begin
        errors++; $display("FAIL random[%0d] %h*%h: got %h lat=%0d expected %h lat=16", i, ra, rb, res, lat, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt, done_at;
    logic [31:0] res, exp;
    exp = ref_mul(16'h1234, 16'h00AB);
    a = 16'h1234; b = 16'h00AB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    a = 16'h0007; b = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    done_cnt = 0; done_at = -1; res = '0;
    for (int n = 5; n < 45; n++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; res = product; end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (res !== exp) begin
      errors++; $display("FAIL busy_start_product: got %h expected %h", res, exp);
    end
    vectors++;
    if (done_cnt != 1 || done_at != 16) begin
      errors++; $display("FAIL busy_start_done: got count=%0d at=%0d expected count=1 at=16", done_cnt, done_at);
    end
  endtask

  task automatic test_flush();
    int lat, bcnt, seen;
    logic [31:0] res;
    a = 16'hBEEF; b = 16'h1357; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      errors++; $display("FAIL flush_state: got busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_done: got %0d done cycles expected 0", seen);
    end
    a = 16'h0005; b = 16'h0005; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_beats_start: got busy=%b expected 0", busy);
    end
    run_op(16'h0002, 16'h0009, lat, bcnt, res);
    vectors++;
    if (res !== ref_mul(16'h0002, 16'h0009) || lat != 16) begin
      errors++; $display("FAIL flush_then_op: got %h lat=%0d expected %h lat=16", res, lat, ref_mul(16'h0002, 16'h0009));
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [31:0] res;
    run_op(16'hABCD, 16'h1234, lat, bcnt, res);
    vectors++;
    if (res !== ref_mul(16'hABCD, 16'h1234) || lat != 16) begin
      errors++; $display("FAIL b2b_first: got %h lat=%0d expected %h lat=16", res, lat, ref_mul(16'hABCD, 16'h1234));
    end
    // Still in the done cycle: the start seen at the next edge re-launches.
    a = 16'h0004; b = 16'h0004; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (product !== ref_mul(16'h0004, 16'h0004) || lat != 16) begin
      errors++; $display("FAIL b2b_second: got %h lat=%0d expected %h lat=16", product, lat, ref_mul(16'h0004, 16'h0004));
    end
  endtask

  task automatic test_async_reset();
    int lat, bcnt;
    logic [31:0] res;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, product} !== 34'h0) begin
      errors++; $display("FAIL async_reset: got busy=%b done=%b product=%h expected all 0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0000, 16'h1234, lat, bcnt, res);
    vectors++;
    if (res !== 32'h0 || lat != 16 || bcnt != 16) begin
      errors++; $display("FAIL reset_then_zero: got %h lat=%0d busy=%0d expected 0 lat=16 busy=16", res, lat, bcnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
